// File: rtl/cram_bank_arbiter.sv
// cram_bank_arbiter: per-bank round-robin arbitration of CPU/DMA-rd/DMA-wr onto four CRAM banks
module cram_bank_arbiter #(
  parameter int BANK_AW = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             req_i,
  input  logic [11:0]            wen_i,
  input  logic [95:0]            addr_i,
  input  logic [95:0]            wdata_i,
  output logic [2:0]             gnt_o,
  output logic [2:0]             rvalid_o,
  output logic [95:0]            rdata_o,
  output logic [3:0]             bank_cs_o,
  output logic [15:0]            bank_wen_o,
  output logic [4*BANK_AW-1:0]   bank_addr_o,
  output logic [127:0]           bank_wdata_o,
  input  logic [127:0]           bank_rdata_i
);
  logic [1:0] r_ptr [4];
  logic [2:0] r_pend;
  logic [1:0] r_rd_bank [3];
  logic [1:0] w_bank [3];
  logic [1:0] w_win [4];
  logic [3:0] w_win_vld;
  logic       w_unused;

  // Only the bank/word bits of each address matter; the rest wrap into the 4 KB space.
  assign w_unused = ^addr_i;
  assign rvalid_o = r_pend;

  // Winner search per bank from its pointer, then grant and bank-side field muxing
  always_comb begin
    logic [1:0] k;
    gnt_o        = '0;
    rdata_o      = '0;
    bank_cs_o    = '0;
    bank_wen_o   = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    w_win_vld    = '0;
    k            = 2'd0;
    for (int p = 0; p < 3; p++) w_bank[p] = addr_i[p*32+BANK_AW+2 +: 2];
    for (int b = 0; b < 4; b++) begin
      w_win[b] = 2'd0;
      k = r_ptr[b];
      for (int o = 0; o < 3; o++) begin
        if (!w_win_vld[b] && req_i[k] && w_bank[k] == 2'(b)) begin
          w_win_vld[b] = 1'b1;
          w_win[b]     = k;
        end
        k = (k == 2'd2) ? 2'd0 : k + 2'd1;
      end
      if (rst_i && w_win_vld[b]) begin
        bank_cs_o[b]                       = 1'b1;
        bank_wen_o[b*4 +: 4]               = wen_i[w_win[b]*4 +: 4];
        bank_addr_o[b*BANK_AW +: BANK_AW]  = addr_i[w_win[b]*32+2 +: BANK_AW];
        bank_wdata_o[b*32 +: 32]           = wdata_i[w_win[b]*32 +: 32];
      end
    end
    for (int p = 0; p < 3; p++) begin
      gnt_o[p] = rst_i && req_i[p] && w_win_vld[w_bank[p]] && (w_win[w_bank[p]] == 2'(p));
      rdata_o[p*32 +: 32] = r_pend[p] ? bank_rdata_i[r_rd_bank[p]*32 +: 32] : 32'd0;
    end
  end

  // Pointer advance past each winner and read-return tracking; reset drops pending reads
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int b = 0; b < 4; b++) r_ptr[b] <= 2'd0;
      for (int p = 0; p < 3; p++) r_rd_bank[p] <= 2'd0;
      r_pend <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (w_win_vld[b]) r_ptr[b] <= (w_win[b] == 2'd2) ? 2'd0 : w_win[b] + 2'd1;
      for (int p = 0; p < 3; p++) begin
        r_pend[p] <= gnt_o[p] && (wen_i[p*4 +: 4] == 4'd0);
        if (gnt_o[p]) r_rd_bank[p] <= w_bank[p];
      end
    end
  end
endmodule

// File: tb/tb_cram_bank_arbiter.sv
// tb_cram_bank_arbiter: directed checks of arbitration, bank muxing, read return and reset
module tb_cram_bank_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   req = '0;
  logic [11:0]  wen = '0;
  logic [95:0]  addr = '0;
  logic [95:0]  wdata = '0;
  logic [2:0]   gnt, rvalid;
  logic [95:0]  rdata;
  logic [3:0]   cs;
  logic [15:0]  bwen;
  logic [31:0]  baddr;
  logic [127:0] bwdata, brdata;
  logic [31:0]  mem [4][256];
  int errors = 0;
  int checks = 0;

  cram_bank_arbiter #(.BANK_AW(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .bank_cs_o(cs), .bank_wen_o(bwen),
    .bank_addr_o(baddr), .bank_wdata_o(bwdata), .bank_rdata_i(brdata)
  );

  always #5 clk = ~clk;

  // SRAM bank model: byte-masked write, registered read one cycle after cs
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (cs[b]) begin
        if (bwen[b*4 +: 4] != 4'd0) begin
          for (int i = 0; i < 4; i++)
            if (bwen[b*4+i]) mem[b][baddr[b*8 +: 8]][i*8 +: 8] <= bwdata[b*32+i*8 +: 8];
        end else brdata[b*32 +: 32] <= mem[b][baddr[b*8 +: 8]];
      end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic port(input int p, input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    req[p] = r;
    wen[p*4 +: 4] = w;
    addr[p*32 +: 32] = a;
    wdata[p*32 +: 32] = d;
  endtask

  initial begin
    brdata = '0;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 256; w++) mem[b][w] = 32'hA5A5_0000 | 32'(b*256 + w);
    // reset held with all ports requesting bank 0
    for (int p = 0; p < 3; p++) port(p, 1'b1, 4'h0, 32'h000, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_cs", cs, 0);
    chk("rst_bank_fields", {bwen, baddr, bwdata[79:0]}, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_gnt", gnt, 3'b001);
    chk("rel_cs", cs, 4'b0001);
    @(negedge clk);
    req = '0;
    #1;
    chk("rel_rvalid", rvalid, 3'b001);
    chk("rel_rdata0", rdata[31:0], 32'hA5A5_0000);
    // three reads to three different banks in one cycle
    port(0, 1'b1, 4'h0, 32'h000, 32'h0);
    port(1, 1'b1, 4'h0, 32'h404, 32'h0);
    port(2, 1'b1, 4'h0, 32'h808, 32'h0);
    #1;
    chk("par_gnt", gnt, 3'b111);
    chk("par_cs", cs, 4'b0111);
    chk("par_addr", baddr, 32'h0002_0100);
    @(negedge clk);
    req = '0;
    #1;
    chk("par_rvalid", rvalid, 3'b111);
    chk("par_rdata", rdata, {32'hA5A5_0202, 32'hA5A5_0101, 32'hA5A5_0000});
    // continuous contention on bank 2
    for (int p = 0; p < 3; p++) port(p, 1'b1, 4'h0, 32'h800, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_gnt%0d", c), gnt, 3'b001 << (c % 3));
      @(negedge clk);
    end
    req = '0;
    // full write from DMA write port, then DMA read of the same word
    port(2, 1'b1, 4'hF, 32'hC10, 32'h1234_5678);
    #1;
    chk("wr_gnt", gnt, 3'b100);
    chk("wr_cs", cs, 4'b1000);
    chk("wr_wen", bwen, 16'hF000);
    chk("wr_addr", baddr[31:24], 8'h04);
    chk("wr_wdata", bwdata[127:96], 32'h1234_5678);
    @(negedge clk);
    req = '0;
    port(1, 1'b1, 4'h0, 32'hC10, 32'h0);
    #1;
    chk("wr_no_rvalid", rvalid, 0);
    chk("rd_after_wr_gnt", gnt, 3'b010);
    @(negedge clk);
    req = '0;
    #1;
    chk("rd_after_wr_rvalid", rvalid, 3'b010);
    chk("rd_after_wr_rdata", rdata[63:32], 32'h1234_5678);
    // partial write from CPU then read-back of the merged word
    port(0, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    #1;
    chk("pw_gnt", gnt, 3'b001);
    chk("pw_wen", bwen, 16'h0003);
    @(negedge clk);
    port(0, 1'b1, 4'h0, 32'h100, 32'h0);
    #1;
    chk("pw_no_rvalid", rvalid, 0);
    @(negedge clk);
    req = '0;
    #1;
    chk("pw_readback", {rvalid, rdata[31:0]}, {3'b001, 32'hA5A5_BEEF});
    // upper address bits ignored
    port(0, 1'b1, 4'h0, 32'hFFFF_F404, 32'h0);
    #1;
    chk("wrap_cs", cs, 4'b0010);
    @(negedge clk);
    req = '0;
    #1;
    chk("wrap_rdata", {rvalid, rdata[31:0]}, {3'b001, 32'hA5A5_0101});
    // contention on bank 0 with pointer at 1, reset before the return cycle
    for (int p = 0; p < 3; p++) port(p, 1'b1, 4'h0, 32'h000, 32'h0);
    #1;
    chk("pre_rst_gnt", gnt, 3'b010);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_gnt", gnt, 3'b001);
    // async reset clears a return already in flight
    @(posedge clk);
    #1;
    chk("inflight_rvalid", rvalid, 3'b001);
    rst = 1'b0;
    #1;
    chk("async_clr", {rvalid, rdata}, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
